// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage.
package lsu_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_e;

    function automatic logic misaligned(size_e size, logic [1:0] addr_lo);
        return ((size == SIZE_HALF) && addr_lo[0]) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side op handshake plus memory bus; master is the LSU, slave is its environment.
interface lsu_if;
    import lsu_pkg::*;

    logic              op_valid;
    logic              op_ready;
    logic              op_we;
    logic [1:0]        op_size;
    logic              op_signed;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              done;
    logic [WORD_W-1:0] rd_data;
    logic              err;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [LANES-1:0]  mem_be;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;

    modport master (
        input  op_valid, op_we, op_size, op_signed, addr, wdata, mem_ack, mem_rdata,
        output op_ready, done, rd_data, err, stall,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output op_valid, op_we, op_size, op_signed, addr, wdata, mem_ack, mem_rdata,
        input  op_ready, done, rd_data, err, stall,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e             size,
    input  logic              sign_ext,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata,
    output logic [LANES-1:0]  be,
    output logic [WORD_W-1:0] wdata_rep,
    output logic [WORD_W-1:0] load_data
);

    logic [BYTE_W-1:0] byte_sel;
    logic [HALF_W-1:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: BYTE_W];
        half_sel  = addr_lo[1] ? rdata[WORD_W-1:HALF_W] : rdata[HALF_W-1:0];
        be        = '0;
        wdata_rep = '0;
        load_data = '0;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {LANES{wdata[BYTE_W-1:0]}};
                load_data = {{(WORD_W-BYTE_W){sign_ext & byte_sel[BYTE_W-1]}}, byte_sel};
            end
            // Half ignores addr[0]; it is only trapped when the misalign trap is built in.
            SIZE_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[HALF_W-1:0]}};
                load_data = {{(WORD_W-HALF_W){sign_ext & half_sel[HALF_W-1]}}, half_sel};
            end
            SIZE_WORD: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                load_data = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: accepts one op, runs a single memory transaction with timeout, reports done/err.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned half/word ops into immediate errors.
//
// state   | meaning
// IDLE    | op_ready=1, waiting for op_valid
// REQ     | mem_req held until mem_ack or timeout
// RESP    | done pulse, err/rd_data presented
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic   clk,
    input  logic   rst_n,
    lsu_if.master  bus
);

    localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              we_q;
    logic              sign_q;
    size_e             size_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata_q;
    logic              err_q;
    logic [15:0]       cnt_q;

    logic              accept;
    logic              timeout;
    logic              bad_op;
    logic [LANES-1:0]  be;
    logic [WORD_W-1:0] wdata_rep;
    logic [WORD_W-1:0] load_data;

    always_comb begin
        bad_op = (size_e'(bus.op_size) == SIZE_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
        bad_op = bad_op | misaligned(size_e'(bus.op_size), bus.addr[1:0]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        timeout      = 1'b0;
        bus.op_ready = 1'b0;
        bus.stall    = 1'b1;
        bus.mem_req  = 1'b0;
        bus.done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.op_ready = 1'b1;
                bus.stall    = 1'b0;
                if (bus.op_valid) begin
                    accept  = 1'b1;
                    state_d = bad_op ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                bus.mem_req = 1'b1;
                // An ack on the terminal-count cycle still completes normally.
                if (bus.mem_ack) begin
                    state_d = ST_RESP;
                end else if (cnt_q == 16'd0) begin
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            we_q    <= bus.op_we;
            sign_q  <= bus.op_signed;
            size_q  <= size_e'(bus.op_size);
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            rdata_q <= '0;
            err_q   <= bad_op;
            cnt_q   <= CNT_LOAD;
        end else if (state_q == ST_REQ) begin
            if (bus.mem_ack)  rdata_q <= we_q ? '0 : load_data;
            else if (timeout) err_q   <= 1'b1;
            else              cnt_q   <= cnt_q - 16'd1;
        end
    end

    lsu_align u_align (
        .size      (size_q),
        .sign_ext  (sign_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (bus.mem_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .load_data (load_data)
    );

    assign bus.mem_addr  = {addr_q[WORD_W-1:2], 2'b00};
    assign bus.mem_be    = (state_q == ST_REQ) ? be : '0;
    assign bus.mem_we    = (state_q == ST_REQ) && we_q;
    assign bus.mem_wdata = wdata_rep;
    assign bus.err       = (state_q == ST_RESP) && err_q;
    assign bus.rd_data   = rdata_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage with TIMEOUT_CYCLES=4; cycle 0 is the cycle the op is accepted.
module tb_lsu_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    lsu_if bus ();

    lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.op_valid  = 1'b1;
        bus.op_we     = we;
        bus.op_size   = size;
        bus.op_signed = sgn;
        bus.addr      = a;
        bus.wdata     = wd;
    endtask

    // Load that is acked in its first REQ cycle; done expected in cycle 2.
    task automatic do_load(input string tag, input logic [1:0] size, input logic sgn,
                           input logic [31:0] a, input logic [31:0] rdata,
                           input logic [3:0] exp_be, input logic [31:0] exp_rd);
        offer(1'b0, size, sgn, a, 32'h5555_AAAA);
        chk({tag, ".ready"}, 32'(bus.op_ready), 32'd1);
        tick();
        bus.op_valid = 1'b0;
        chk({tag, ".req"},   32'(bus.mem_req), 32'd1);
        chk({tag, ".we"},    32'(bus.mem_we), 32'd0);
        chk({tag, ".be"},    32'(bus.mem_be), 32'(exp_be));
        chk({tag, ".maddr"}, bus.mem_addr, {a[31:2], 2'b00});
        chk({tag, ".done1"}, 32'(bus.done), 32'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack = 1'b0;
        chk({tag, ".done2"}, 32'(bus.done), 32'd1);
        chk({tag, ".err"},   32'(bus.err), 32'd0);
        chk({tag, ".rd"},    bus.rd_data, exp_rd);
        chk({tag, ".reqoff"}, 32'(bus.mem_req), 32'd0);
        tick();
        chk({tag, ".pulse"}, 32'(bus.done), 32'd0);
        chk({tag, ".idle"},  32'(bus.op_ready), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.op_valid  = 1'b0;
        bus.op_we     = 1'b0;
        bus.op_size   = 2'b00;
        bus.op_signed = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;

        #3;
        chk("rst.ready", 32'(bus.op_ready), 32'd1);
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.done",  32'(bus.done), 32'd0);
        chk("rst.err",   32'(bus.err), 32'd0);
        chk("rst.rd",    bus.rd_data, 32'd0);
        chk("rst.req",   32'(bus.mem_req), 32'd0);
        chk("rst.we",    32'(bus.mem_we), 32'd0);
        chk("rst.be",    32'(bus.mem_be), 32'd0);
        chk("rst.maddr", bus.mem_addr, 32'd0);
        chk("rst.wdata", bus.mem_wdata, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Signed byte from lane 3.
        do_load("ldb_s", 2'b00, 1'b1, 32'h0000_0103, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
        do_load("ldb_u", 2'b00, 1'b0, 32'h0000_0001, 32'h0000_F100, 4'b0010, 32'h0000_00F1);
        do_load("ldh_u", 2'b01, 1'b0, 32'h0000_0002, 32'h8001_7FFF, 4'b1100, 32'h0000_8001);
        do_load("ldh_s", 2'b01, 1'b1, 32'h0000_0010, 32'h1234_9ABC, 4'b0011, 32'hFFFF_9ABC);
        do_load("ldw",   2'b10, 1'b1, 32'h0000_0ABC, 32'h8765_4321, 4'b1111, 32'h8765_4321);

        // Stray ack while idle must not produce a completion.
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        chk("stray.done",  32'(bus.done), 32'd0);
        chk("stray.stall", 32'(bus.stall), 32'd0);

        // Half store with ack on the 4th REQ cycle (also the terminal-count cycle).
        offer(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_BEEF);
        chk("sth.ready", 32'(bus.op_ready), 32'd1);
        tick();
        bus.op_valid  = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            chk("sth.req",   32'(bus.mem_req), 32'd1);
            chk("sth.we",    32'(bus.mem_we), 32'd1);
            chk("sth.be",    32'(bus.mem_be), 32'b1100);
            chk("sth.wdata", bus.mem_wdata, 32'hBEEF_BEEF);
            chk("sth.maddr", bus.mem_addr, 32'h0000_0020);
            chk("sth.nodone", 32'(bus.done), 32'd0);
            if (i == 3) bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        chk("sth.done",  32'(bus.done), 32'd1);
        chk("sth.err",   32'(bus.err), 32'd0);
        chk("sth.rd",    bus.rd_data, 32'd0);
        chk("sth.reqoff", 32'(bus.mem_req), 32'd0);
        tick();

        // Load rd_data is nonzero before this; timeout must clear it.
        do_load("ldpre", 2'b10, 1'b0, 32'h0000_0100, 32'h1357_9BDF, 4'b1111, 32'h1357_9BDF);
        offer(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        bus.op_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo.req",    32'(bus.mem_req), 32'd1);
            chk("tmo.nodone", 32'(bus.done), 32'd0);
            tick();
        end
        chk("tmo.reqoff", 32'(bus.mem_req), 32'd0);
        chk("tmo.done",   32'(bus.done), 32'd1);
        chk("tmo.err",    32'(bus.err), 32'd1);
        chk("tmo.rd",     bus.rd_data, 32'd0);
        tick();
        chk("tmo.pulse",  32'(bus.done), 32'd0);

        // Misaligned word load at 0x6.
        offer(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
        tick();
        bus.op_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis.req",  32'(bus.mem_req), 32'd0);
        chk("mis.done", 32'(bus.done), 32'd1);
        chk("mis.err",  32'(bus.err), 32'd1);
        tick();
`else
        chk("mis.req",   32'(bus.mem_req), 32'd1);
        chk("mis.maddr", bus.mem_addr, 32'h0000_0004);
        chk("mis.be",    32'(bus.mem_be), 32'b1111);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus.mem_ack = 1'b0;
        chk("mis.done", 32'(bus.done), 32'd1);
        chk("mis.err",  32'(bus.err), 32'd0);
        chk("mis.rd",   bus.rd_data, 32'hCAFE_F00D);
        tick();
`endif

        // Reserved size, then a back-to-back op held on op_valid.
        offer(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0);
        chk("rsv.ready", 32'(bus.op_ready), 32'd1);
        tick();
        offer(1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0);
        chk("rsv.req",   32'(bus.mem_req), 32'd0);
        chk("rsv.done",  32'(bus.done), 32'd1);
        chk("rsv.err",   32'(bus.err), 32'd1);
        chk("rsv.busy",  32'(bus.op_ready), 32'd0);
        tick();
        chk("b2b.ready", 32'(bus.op_ready), 32'd1);
        chk("b2b.nodone", 32'(bus.done), 32'd0);
        tick();
        bus.op_valid = 1'b0;
        chk("b2b.req",   32'(bus.mem_req), 32'd1);
        chk("b2b.be",    32'(bus.mem_be), 32'b0001);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_00A5;
        tick();
        bus.mem_ack = 1'b0;
        chk("b2b.done",  32'(bus.done), 32'd1);
        chk("b2b.rd",    bus.rd_data, 32'h0000_00A5);
        tick();

        // Reset two cycles into REQ, applied between clock edges.
        offer(1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h1122_3344);
        tick();
        bus.op_valid = 1'b0;
        chk("rstm.req1", 32'(bus.mem_req), 32'd1);
        tick();
        chk("rstm.req2", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstm.reqoff", 32'(bus.mem_req), 32'd0);
        chk("rstm.we",     32'(bus.mem_we), 32'd0);
        chk("rstm.stall",  32'(bus.stall), 32'd0);
        chk("rstm.ready",  32'(bus.op_ready), 32'd1);
        tick();
        chk("rstm.nodone", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rstm.rel_ready", 32'(bus.op_ready), 32'd1);
        chk("rstm.rel_done",  32'(bus.done), 32'd0);
        tick();
        chk("rstm.rel_done2", 32'(bus.done), 32'd0);

        do_load("post", 2'b00, 1'b1, 32'h0000_0200, 32'h0000_007F, 4'b0001, 32'h0000_007F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles waiting for mem_ack before abort (1..65535).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 op_valid  in  1  memory op offered by execute stage.
REQ-005 op_ready  out  1  lsu_stage accepts op this cycle.
REQ-006 op_we  in  1  1=store, 0=load.
REQ-007 op_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 op_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-009 addr  in  32  byte address (ALU result).
REQ-010 wdata  in  32  store data (forwarded busA).
REQ-011 done  out  1  one-cycle pulse: op finished (load or store, ok or error).
REQ-012 rd_data  out  32  load result, valid when done=1 and op was a load.
REQ-013 err  out  1  coincident with done: reserved size, misalignment or timeout.
REQ-014 stall  out  1  high whenever state is not IDLE.
REQ-015 mem_req / mem_we  out  1 / 1  memory request and write strobe.
REQ-016 mem_addr  out  32  word address, bits [1:0] always 0.
REQ-017 mem_be  out  4  byte enables, lane n = bits [8n+7:8n], little-endian.
REQ-018 mem_wdata  out  32  lane-replicated store data.
REQ-019 mem_ack / mem_rdata  in  1 / 32  request completion and read word.

Function
REQ-020 FSM states IDLE, REQ, RESP; op_ready=1 only in IDLE.
REQ-021 IDLE: op_valid=1 latches op_we, op_size, op_signed, addr, wdata; next state REQ, or RESP with err=1 if size=11 or misaligned (see Configuration); no mem_req on error.
REQ-022 REQ: mem_req=1, mem_addr, mem_we, mem_be, mem_wdata held constant until mem_ack=1; on mem_ack, capture mem_rdata and go RESP.
REQ-023 RESP: done=1 for exactly one cycle, rd_data driven, then IDLE; next op acceptable the following cycle.
REQ-024 Latency: mem_ack in first REQ cycle gives done 2 cycles after acceptance edge; each extra wait cycle adds one.
REQ-025 mem_be: byte = 1<<addr[1:0]; half = 0011 (addr[1]=0) or 1100; word = 1111.
REQ-026 mem_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-027 Load: select lane(s) by addr[1:0], extend to 32 bits per op_signed; word ignores op_signed; stores drive rd_data=0.
REQ-028 Timeout: cycle counter cleared on REQ entry; when TIMEOUT_CYCLES REQ cycles elapse without mem_ack, drop mem_req, go RESP with err=1, rd_data=0.
REQ-029 mem_ack outside REQ is ignored; op_valid outside IDLE is ignored (upstream holds via stall).

Reset
REQ-030 rst_n low: state IDLE, counter 0, done=0, err=0, rd_data=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0; op_ready=1, stall=0.
REQ-031 Reset mid-REQ drops mem_req immediately (asynchronously); the in-flight op is discarded with no done.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 yields err=1 and done with no memory access.
REQ-033 Macro undefined: misaligned ops execute with ignored low bits (half uses addr[1] only, word uses lane 0); err only for size=11 or timeout.

Structure
REQ-034 Package lsu_pkg holds op_size encodings, FSM state enum, and lane-width constants.
REQ-035 Sub-module lsu_align (combinational) performs byte-enable generation, store replication and load extraction/extension; lsu_stage holds FSM, counter and registers.

Verification
REQ-036 Load byte signed, addr=0x103, mem_rdata=0x80FF_1234, ack 1st cycle -> mem_be=1000, mem_addr=0x100, rd_data=0xFFFF_FF80, done 2 cycles after accept.
REQ-037 Store half, addr=0x22, wdata=0x0000_BEEF, ack after 3 waits -> mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1 held 4 cycles, done 5 cycles after accept.
REQ-038 TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then done=1, err=1, rd_data=0.
REQ-039 Word load addr=0x6: with LSU_MISALIGN_TRAP_EN -> no mem_req, done+err next cycle; without -> mem_addr=0x4, mem_be=1111, err=0.
REQ-040 rst_n asserted 2 cycles into REQ -> mem_req falls without clock edge, no done, op_ready=1 after release.
REQ-041 op_size=11 -> no mem_req, done+err next cycle; back-to-back op accepted the cycle after done.
